// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: shared state enum and default parameter constants
package pc_sequencer_pkg;
  typedef enum logic {RUN, HALT} state_t;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_STEP = 2;
  localparam int DEF_RESET_VEC = 0;
  localparam int DEF_RAS_DEPTH = 4;
endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: control inputs and pc/stack status outputs of the sequencer
interface pc_sequencer_if import pc_sequencer_pkg::*; #(parameter int ADDR_W = DEF_ADDR_W) ();
  logic hlt;
  logic stall;
  logic br_taken;
  logic [ADDR_W-1:0] br_target;
  logic call;
  logic ret;
  logic [ADDR_W-1:0] pc_addr;
  logic [ADDR_W-1:0] pc_next;
  logic halted;
  logic ras_empty;
  logic ras_full;
  logic ras_ovf;
  logic ras_unf;
  modport master (
    output hlt, stall, br_taken, br_target, call, ret,
    input pc_addr, pc_next, halted, ras_empty, ras_full, ras_ovf, ras_unf
  );
  modport slave (
    input hlt, stall, br_taken, br_target, call, ret,
    output pc_addr, pc_next, halted, ras_empty, ras_full, ras_ovf, ras_unf
  );
endinterface

// File: rtl/pc_sequencer_ras_stack.sv
// ras_stack: circular return-address LIFO with occupancy and sticky ovf/unf flags
module ras_stack #(
  parameter int W = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top_data,
  output logic         empty,
  output logic         full,
  output logic         ovf,
  output logic         unf
);
  localparam int PW = $clog2(DEPTH);
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d, unf_q, unf_d;
  logic [W-1:0] mem_q [DEPTH];
  assign empty = cnt_q == '0;
  assign full = cnt_q == (PW+1)'(DEPTH);
  assign ovf = ovf_q;
  assign unf = unf_q;
  assign top_data = mem_q[ptr_q - PW'(1)];
  always_comb begin
    ptr_d = push ? ptr_q + PW'(1) : (pop && !empty) ? ptr_q - PW'(1) : ptr_q;
    cnt_d = push ? (full ? cnt_q : cnt_q + (PW+1)'(1)) : (pop && !empty) ? cnt_q - (PW+1)'(1) : cnt_q;
    ovf_d = ovf_q | (push & full);
    unf_d = unf_q | (pop & empty);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[ptr_q] <= push_data;
  end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter with branch/call/return redirection, halt and return-address stack
module pc_sequencer import pc_sequencer_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int STEP = DEF_STEP,
  parameter int RESET_VEC = DEF_RESET_VEC,
  parameter int RAS_DEPTH = DEF_RAS_DEPTH
) (
  input logic clk,
  input logic rst,
  pc_sequencer_if.slave bus
);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_seq, ras_top;
  logic active, do_ret, do_call, ras_empty;
  assign pc_seq = pc_q + ADDR_W'(STEP);
  always_comb begin
    active = state_q == RUN && !bus.hlt && !bus.stall;
    do_ret = active && bus.ret;
    do_call = active && bus.call && !bus.ret;
    state_d = (state_q == RUN && bus.hlt) ? HALT : state_q;
    bus.pc_next = rst ? ADDR_W'(RESET_VEC) :
                  !active ? pc_q :
                  do_ret ? (ras_empty ? pc_seq : ras_top) :
                  (do_call || bus.br_taken) ? bus.br_target : pc_seq;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q <= ADDR_W'(RESET_VEC);
    end else begin
      state_q <= state_d;
      pc_q <= bus.pc_next;
    end
  end
  assign bus.pc_addr = pc_q;
  assign bus.halted = state_q == HALT;
  assign bus.ras_empty = ras_empty;
  ras_stack #(.W(ADDR_W), .DEPTH(RAS_DEPTH)) u_ras (
    .clk(clk),
    .rst(rst),
    .push(do_call),
    .pop(do_ret),
    .push_data(pc_seq),
    .top_data(ras_top),
    .empty(ras_empty),
    .full(bus.ras_full),
    .ovf(bus.ras_ovf),
    .unf(bus.ras_unf)
  );
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed self-checking bench for pc_sequencer
module tb_pc_sequencer;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  pc_sequencer_if #(.ADDR_W(16)) bus ();
  pc_sequencer dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    bus.hlt = 0;
    bus.stall = 0;
    bus.br_taken = 0;
    bus.br_target = '0;
    bus.call = 0;
    bus.ret = 0;
  endtask
  task automatic jump(input logic [15:0] t);
    bus.br_taken = 1;
    bus.br_target = t;
    step();
    idle();
  endtask
  task automatic do_reset();
    idle();
    rst = 1;
    step();
    rst = 0;
  endtask
  task automatic test_reset();
    bus.hlt = 1;
    bus.br_taken = 1;
    bus.br_target = 16'h1234;
    rst = 1;
    step();
    rst = 0;
    idle();
    checks++;
    if (bus.pc_addr !== 16'h0000) begin errors++; $display("FAIL reset_pc got %h exp 0000", bus.pc_addr); end
    checks++;
    if ({bus.halted, bus.ras_empty, bus.ras_full, bus.ras_ovf, bus.ras_unf} !== 5'b01000) begin
      errors++;
      $display("FAIL reset_flags got %b exp 01000", {bus.halted, bus.ras_empty, bus.ras_full, bus.ras_ovf, bus.ras_unf});
    end
  endtask
  task automatic test_sequential();
    logic [15:0] exp [4] = '{16'h0002, 16'h0004, 16'h0006, 16'h0008};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (bus.pc_addr !== exp[i]) begin errors++; $display("FAIL seq%0d got %h exp %h", i, bus.pc_addr, exp[i]); end
    end
  endtask
  task automatic test_branch();
    jump(16'h0010);
    bus.stall = 1;
    bus.br_taken = 1;
    bus.br_target = 16'h0100;
    #1;
    checks++;
    if (bus.pc_next !== 16'h0010) begin errors++; $display("FAIL stall_next got %h exp 0010", bus.pc_next); end
    step();
    checks++;
    if (bus.pc_addr !== 16'h0010) begin errors++; $display("FAIL stall_pc got %h exp 0010", bus.pc_addr); end
    bus.stall = 0;
    #1;
    checks++;
    if (bus.pc_next !== 16'h0100) begin errors++; $display("FAIL br_next got %h exp 0100", bus.pc_next); end
    step();
    idle();
    checks++;
    if (bus.pc_addr !== 16'h0100) begin errors++; $display("FAIL br_pc got %h exp 0100", bus.pc_addr); end
  endtask
  task automatic test_call_ret();
    do_reset();
    jump(16'h0020);
    bus.call = 1;
    bus.br_target = 16'h0200;
    step();
    idle();
    checks++;
    if (bus.pc_addr !== 16'h0200 || bus.ras_empty !== 1'b0) begin
      errors++;
      $display("FAIL call got pc %h empty %b exp 0200 0", bus.pc_addr, bus.ras_empty);
    end
    repeat (3) step();
    checks++;
    if (bus.pc_addr !== 16'h0206) begin errors++; $display("FAIL call_body got %h exp 0206", bus.pc_addr); end
    bus.ret = 1;
    bus.call = 1;
    bus.br_target = 16'h0999;
    step();
    idle();
    checks++;
    if (bus.pc_addr !== 16'h0022 || bus.ras_empty !== 1'b1) begin
      errors++;
      $display("FAIL ret got pc %h empty %b exp 0022 1", bus.pc_addr, bus.ras_empty);
    end
  endtask
  task automatic test_nested();
    logic [15:0] rets [5] = '{16'h0402, 16'h0302, 16'h0202, 16'h0102, 16'h0104};
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      bus.call = 1;
      bus.br_taken = (i == 3);
      bus.br_target = 16'(i * 16'h0100);
      step();
      idle();
      if (i == 4) begin
        checks++;
        if (bus.ras_full !== 1'b1 || bus.ras_ovf !== 1'b0) begin
          errors++;
          $display("FAIL full4 got full %b ovf %b exp 1 0", bus.ras_full, bus.ras_ovf);
        end
      end
    end
    checks++;
    if ({bus.pc_addr, bus.ras_full, bus.ras_ovf} !== {16'h0500, 2'b11}) begin
      errors++;
      $display("FAIL ovf got pc %h full %b ovf %b exp 0500 1 1", bus.pc_addr, bus.ras_full, bus.ras_ovf);
    end
    for (int i = 0; i < 5; i++) begin
      bus.ret = 1;
      step();
      idle();
      checks++;
      if (bus.pc_addr !== rets[i]) begin errors++; $display("FAIL ret%0d got %h exp %h", i, bus.pc_addr, rets[i]); end
    end
    checks++;
    if ({bus.ras_empty, bus.ras_full, bus.ras_ovf, bus.ras_unf} !== 4'b1011) begin
      errors++;
      $display("FAIL unf got %b exp 1011", {bus.ras_empty, bus.ras_full, bus.ras_ovf, bus.ras_unf});
    end
  endtask
  task automatic test_wrap();
    jump(16'hFFFE);
    step();
    checks++;
    if (bus.pc_addr !== 16'h0000) begin errors++; $display("FAIL wrap got %h exp 0000", bus.pc_addr); end
  endtask
  task automatic test_halt();
    int bad = 0;
    do_reset();
    jump(16'h0040);
    bus.hlt = 1;
    bus.br_taken = 1;
    bus.br_target = 16'h1234;
    step();
    bus.hlt = 0;
    checks++;
    if (bus.halted !== 1'b1 || bus.pc_addr !== 16'h0040) begin
      errors++;
      $display("FAIL halt got halted %b pc %h exp 1 0040", bus.halted, bus.pc_addr);
    end
    for (int i = 0; i < 10; i++) begin
      bus.call = i[0];
      bus.ret = i[1];
      step();
      checks++;
      if (bus.halted !== 1'b1 || bus.pc_addr !== 16'h0040) begin
        errors++;
        $display("FAIL halt_hold%0d got halted %b pc %h exp 1 0040", i, bus.halted, bus.pc_addr);
      end
    end
    rst = 1;
    step();
    rst = 0;
    idle();
    checks++;
    if (bus.halted !== 1'b0 || bus.pc_addr !== 16'h0000) begin
      errors++;
      $display("FAIL halt_rst got halted %b pc %h exp 0 0000", bus.halted, bus.pc_addr);
    end
    step();
    checks++;
    if (bus.pc_addr !== 16'h0002) begin errors++; $display("FAIL halt_restart got %h exp 0002", bus.pc_addr); end
  endtask
  initial begin
    rst = 1;
    idle();
    test_reset();
    test_sequential();
    test_branch();
    test_call_ret();
    test_nested();
    test_wrap();
    test_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter ADDR_W, default 16, PC and target width in bits.
REQ-002 Parameter STEP, default 2, sequential increment in bytes.
REQ-003 Parameter RESET_VEC, default 0, PC value loaded on reset.
REQ-004 Parameter RAS_DEPTH, default 4, return-address-stack entries (power of two, >=2).
REQ-005 clk  in  1  system clock; all state updates on posedge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 hlt  in  1  halt request.
REQ-008 stall  in  1  hold PC this cycle.
REQ-009 br_taken  in  1  redirect PC to br_target.
REQ-010 br_target  in  ADDR_W  branch/call destination.
REQ-011 call  in  1  push return address, jump to br_target.
REQ-012 ret  in  1  pop return address into PC.
REQ-013 pc_addr  out  ADDR_W  registered current PC (instruction fetch address).
REQ-014 pc_next  out  ADDR_W  combinational value PC takes at next posedge.
REQ-015 halted  out  1  registered; PC frozen.
REQ-016 ras_empty, ras_full  out  1 each  stack occupancy flags.
REQ-017 ras_ovf, ras_unf  out  1 each  sticky overflow/underflow flags.

Function
REQ-018 Two states: RUN, HALT; RUN->HALT when hlt=1 in RUN; HALT exits only via rst.
REQ-019 pc_next priority: HALT or hlt -> pc_addr; stall -> pc_addr; ret -> popped address; call or br_taken -> br_target; else pc_addr+STEP.
REQ-020 Arithmetic modulo 2^ADDR_W; pc_addr+STEP at all-ones region wraps to low addresses, no flag.
REQ-021 pc_addr <= pc_next every cycle; update latency one cycle.
REQ-022 halted asserts the cycle after hlt is sampled; the PC value sampled with hlt remains on pc_addr.
REQ-023 call (not stalled, not halting): pushes pc_addr+STEP (wrapped), PC <= br_target.
REQ-024 ret (not stalled, not halting): pops top entry into PC; call in the same cycle ignored.
REQ-025 stall or hlt suppresses push, pop, br_taken and call for that cycle.
REQ-026 Push when full: oldest entry overwritten (circular), occupancy stays RAS_DEPTH, ras_ovf sets.
REQ-027 ret when empty: PC <= pc_addr+STEP, occupancy stays 0, ras_unf sets.
REQ-028 ras_empty = occupancy 0; ras_full = occupancy RAS_DEPTH; both registered-state derived.
REQ-029 br_taken with call: identical to call (target shared).

Reset
REQ-030 rst=1 at posedge: pc_addr=RESET_VEC, state RUN, halted=0, occupancy 0, ras_empty=1, ras_full=0, ras_ovf=0, ras_unf=0; overrides all other inputs.
REQ-031 Stack entry contents after reset are don't-care and never observable.
REQ-032 Reset mid-halt or mid-stall restarts fetch at RESET_VEC next cycle.

Structure
REQ-033 Shared package holds state enum (RUN, HALT) and default parameter constants.
REQ-034 One sub-module, ras_stack (circular LIFO with push/pop/occupancy/ovf), instantiated once.
REQ-035 Single PC register; no latches; pc_next is the only combinational output.

Verification
REQ-036 Reset then 4 idle cycles, defaults -> pc_addr 0x0000,0x0002,0x0004,0x0006,0x0008.
REQ-037 PC=0x0010, br_taken=1 target 0x0100 -> next 0x0100; stall=1 same cycle instead -> stays 0x0010.
REQ-038 PC=0x0020 call target 0x0200; later ret at 0x0206 -> PC 0x0022; ras_empty back to 1.
REQ-039 Five nested calls, RAS_DEPTH=4 -> ras_ovf=1, ras_full=1; four rets return the four newest addresses; fifth ret -> ras_unf=1, PC+2.
REQ-040 PC=0xFFFE, no branch -> 0x0000; hlt at PC=0x0040 -> halted=1 next cycle, PC holds 0x0040 for 10 cycles despite br_taken; rst -> 0x0000, halted=0.
